// File: rtl/bist_pkg.sv
// Shared BIST definitions: ORA state encoding and default signature settings.
package bist_pkg;

    // CUT response width, shared with the pattern generator and CUT wrapper
    localparam int RESP_W = 2;

    // Default MISR configuration for the full-adder BIST loop
    localparam int         DEF_SIG_W  = 8;
    localparam logic [7:0] DEF_POLY   = 8'h1D;  // x^8+x^4+x^3+x^2+1, MSB implicit
    localparam logic [7:0] DEF_SEED   = 8'h00;
    localparam logic [7:0] DEF_GOLDEN = 8'h47;

    typedef enum logic [1:0] {
        IDLE,
        COMPACT,
        COMPARE,
        DONE
    } state_t;

endpackage

// File: rtl/bist_ora_misr.sv
// Multiple-input signature register: Galois-style shift with XOR feedback,
// folding one zero-extended response word in per enabled cycle.
module misr
    import bist_pkg::*;
#(
    parameter int               SIG_W   = DEF_SIG_W,
    parameter logic [SIG_W-1:0] POLY    = DEF_POLY,
    parameter logic [SIG_W-1:0] RST_VAL = DEF_SEED
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [SIG_W-1:0] seed,
    input  logic             en,
    input  logic [SIG_W-1:0] din,
    output logic [SIG_W-1:0] sig
);

    // Load takes priority over compaction so a restart always begins clean
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig <= RST_VAL;
        end else if (load) begin
            sig <= seed;
        end else if (en) begin
            sig <= {sig[SIG_W-2:0], 1'b0} ^ (sig[SIG_W-1] ? POLY : '0) ^ din;
        end
    end

endmodule

// File: rtl/bist_ora.sv
// BIST output response analyzer: compacts NUM_PATTERNS CUT responses into a
// MISR, compares against GOLDEN and reports pass/fail to the controller.
module bist_ora #(
    parameter int               RESP_W       = bist_pkg::RESP_W,
    parameter int               SIG_W        = bist_pkg::DEF_SIG_W,
    parameter int               NUM_PATTERNS = 8,
    parameter logic [SIG_W-1:0] POLY         = bist_pkg::DEF_POLY,
    parameter logic [SIG_W-1:0] SEED         = bist_pkg::DEF_SEED,
    parameter logic [SIG_W-1:0] GOLDEN       = bist_pkg::DEF_GOLDEN,
    localparam int              CNT_W        = $clog2(NUM_PATTERNS + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              resp_valid,
    input  logic [RESP_W-1:0] resp,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [SIG_W-1:0]  signature,
    output logic [CNT_W-1:0]  count
);

    import bist_pkg::*;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_PATTERNS - 1);

    state_t state, state_nxt;
    logic   load;    // (re)start a run: seed MISR, clear count and pass
    logic   accept;  // valid response taken into the MISR this cycle

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next state; start is honoured only when no run is in flight
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        accept    = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = COMPACT;
                end
            end
            COMPACT: begin
                if (resp_valid) begin
                    accept = 1'b1;
                    if (count == LAST) state_nxt = COMPARE;
                end
            end
            COMPARE: state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end

    // Accepted-response counter; stops at NUM_PATTERNS since COMPACT exits on the last beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      count <= '0;
        else if (load)   count <= '0;
        else if (accept) count <= count + CNT_W'(1);
    end

    // Verdict captured once in COMPARE, held through DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                 pass <= 1'b0;
        else if (load)              pass <= 1'b0;
        else if (state == COMPARE)  pass <= (signature == GOLDEN);
    end

    assign busy = (state == COMPACT) || (state == COMPARE);
    assign done = (state == DONE);

    misr #(
        .SIG_W   (SIG_W),
        .POLY    (POLY),
        .RST_VAL (SEED)
    ) u_misr (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load),
        .seed  (SEED),
        .en    (accept),
        .din   (SIG_W'(resp)),
        .sig   (signature)
    );

endmodule

// File: tb/tb_bist_ora.sv
// Self-checking bench for bist_ora: spec vectors, hand sequences, random runs.
module tb_bist_ora;

    logic       clk = 1'b0;
    logic       rst_n, start, resp_valid;
    logic [1:0] resp;

    logic       busy, done, pass;
    logic [7:0] signature;
    logic [3:0] count;

    logic       busy2, done2, pass2;
    logic [7:0] signature2;
    logic [3:0] count2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bist_ora dut (
        .clk(clk), .rst_n(rst_n), .start(start), .resp_valid(resp_valid), .resp(resp),
        .busy(busy), .done(done), .pass(pass), .signature(signature), .count(count)
    );

    // Second instance with MSB set in the seed exercises the feedback taps
    bist_ora #(.SEED(8'h80)) dut_fb (
        .clk(clk), .rst_n(rst_n), .start(start), .resp_valid(resp_valid), .resp(resp),
        .busy(busy2), .done(done2), .pass(pass2), .signature(signature2), .count(count2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: polynomial division over GF(2) written as plain integer arithmetic
    function automatic logic [7:0] ref_sig(input int seed, input logic [1:0] q[$]);
        int s;
        s = seed;
        foreach (q[i]) begin
            s = s * 2;
            if (s > 255) s = (s - 256) ^ 'h1D;
            s = s ^ int'(q[i]);
        end
        return 8'(s);
    endfunction

    typedef struct {
        string      name;
        logic [1:0] r[8];
        int         gap[8];
        int         start_beat;
        logic [7:0] exp_sig;
        logic       exp_pass;
    } vec_t;

    vec_t       tbl[4];
    logic [1:0] cur_r[8];
    int         cur_gap[8];
    int         cur_sb;

    // One full run from DONE/IDLE using cur_* stimulus
    task automatic run_cur(input string nm, input logic [7:0] esig, input logic epass);
        int         cyc, w, gaps;
        logic [1:0] q[$];
        logic [7:0] held;
        gaps = 0;
        @(negedge clk); start = 1'b1; resp_valid = 1'b0;
        @(negedge clk); start = 1'b0; cyc = 1;
        chk({nm, ".busy_after_start"}, busy, 1);
        chk({nm, ".count_loaded"}, count, 0);
        chk({nm, ".sig_loaded"}, signature, 8'h00);
        for (int b = 0; b < 8; b++) begin
            resp_valid = 1'b1;
            resp       = cur_r[b];
            start      = (b == cur_sb);
            @(negedge clk); cyc++;
            resp_valid = 1'b0;
            start      = 1'b0;
            resp       = 2'($urandom);
            q.push_back(cur_r[b]);
            chk($sformatf("%s.sig_beat%0d", nm, b), signature, ref_sig(0, q));
            chk($sformatf("%s.cnt_beat%0d", nm, b), count, b + 1);
            for (int g = 0; g < cur_gap[b]; g++) begin
                @(negedge clk); cyc++; gaps++;
            end
        end
        chk({nm, ".compare_busy"}, busy, 1);
        chk({nm, ".compare_not_done"}, done, 0);
        w = 0;
        while (!done && w < 5) begin
            @(negedge clk); w++; cyc++;
        end
        chk({nm, ".done_latency"}, w, 1);
        chk({nm, ".run_cycles"}, cyc, 10 + gaps);
        chk({nm, ".busy_done"}, busy, 0);
        chk({nm, ".pass"}, pass, epass);
        chk({nm, ".sig"}, signature, esig);
        chk({nm, ".count"}, count, 8);
        // Valid responses in DONE must not disturb the held result
        held = signature;
        resp_valid = 1'b1; resp = 2'b11;
        repeat (2) @(negedge clk);
        resp_valid = 1'b0;
        chk({nm, ".done_hold_sig"}, signature, held);
        chk({nm, ".done_hold_cnt"}, count, 8);
        chk({nm, ".done_hold_pass"}, pass, epass);
        chk({nm, ".done_hold_done"}, done, 1);
    endtask

    task automatic load_vec(input int i);
        for (int b = 0; b < 8; b++) begin
            cur_r[b]   = tbl[i].r[b];
            cur_gap[b] = tbl[i].gap[b];
        end
        cur_sb = tbl[i].start_beat;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] q[$];
        logic [7:0] es;

        for (int i = 0; i < 4; i++) begin
            tbl[i].r          = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};
            tbl[i].start_beat = -1;
            tbl[i].exp_sig    = 8'h47;
            tbl[i].exp_pass   = 1'b1;
            for (int b = 0; b < 8; b++) tbl[i].gap[b] = 0;
        end
        tbl[0].name = "fault_free";
        tbl[1].name = "stuck_at";  tbl[1].r[7] = 2'b10; tbl[1].exp_sig = 8'h46; tbl[1].exp_pass = 1'b0;
        tbl[2].name = "gapped";    tbl[2].gap[3] = 3;
        tbl[3].name = "mid_start"; tbl[3].start_beat = 2;

        rst_n = 1'b0; start = 1'b0; resp_valid = 1'b0; resp = 2'b00;
        repeat (2) @(negedge clk);
        chk("rst.sig", signature, 8'h00);
        chk("rst.count", count, 0);
        chk("rst.busy", busy, 0);
        chk("rst.done", done, 0);
        chk("rst.pass", pass, 0);
        chk("rst.sig_fb", signature2, 8'h80);
        rst_n = 1'b1;

        // Responses while IDLE are ignored
        resp_valid = 1'b1; resp = 2'b11;
        repeat (3) @(negedge clk);
        resp_valid = 1'b0;
        chk("idle_valid.sig", signature, 8'h00);
        chk("idle_valid.count", count, 0);
        chk("idle_valid.busy", busy, 0);

        for (int i = 0; i < 4; i++) begin
            load_vec(i);
            run_cur(tbl[i].name, tbl[i].exp_sig, tbl[i].exp_pass);
        end

        // Feedback path: eight zero responses from seed 80 on the second instance
        for (int b = 0; b < 8; b++) begin cur_r[b] = 2'b00; cur_gap[b] = 0; end
        cur_sb = -1;
        run_cur("zeros", 8'h00, 1'b0);
        chk("feedback.sig", signature2, 8'h26);
        chk("feedback.pass", pass2, 0);
        chk("feedback.done", done2, 1);

        // Reset mid-run: abort after beat 5 and check asynchronous return
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int b = 0; b < 5; b++) begin
            resp_valid = 1'b1; resp = tbl[0].r[b];
            @(negedge clk);
        end
        resp_valid = 1'b0;
        chk("midrst.pre_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("midrst.sig", signature, 8'h00);
        chk("midrst.count", count, 0);
        chk("midrst.busy", busy, 0);
        chk("midrst.done", done, 0);
        chk("midrst.pass", pass, 0);
        chk("midrst.sig_fb", signature2, 8'h80);
        @(negedge clk); rst_n = 1'b1;
        load_vec(0);
        run_cur("after_rst", 8'h47, 1'b1);

        // Random runs against the reference model
        for (int n = 0; n < 8; n++) begin
            q.delete();
            for (int b = 0; b < 8; b++) begin
                cur_r[b]   = 2'($urandom);
                cur_gap[b] = (b == 7) ? 0 : int'($urandom_range(0, 2));
                q.push_back(cur_r[b]);
            end
            cur_sb = int'($urandom_range(0, 9));
            es = ref_sig(0, q);
            run_cur($sformatf("rand%0d", n), es, es == 8'h47);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bist_ora.md
# bist_ora

Output response analyzer for the BIST loop: sits directly downstream of the circuit under test (the full adder) and consumes its 2-bit `{cout, sum}` response once per applied pattern. It compacts a fixed-length response stream into a multiple-input signature register (MISR), compares the final signature against a golden value, and reports pass/fail to the BIST controller.

## Interface
- `RESP_W`, 2: width of the CUT response; bit 1 = cout, bit 0 = sum.
- `SIG_W`, 8: MISR/signature width; must be ≥ `RESP_W`.
- `NUM_PATTERNS`, 8: number of valid responses compacted per run; must be ≥ 1.
- `POLY`, 8'h1D: feedback taps, x^8+x^4+x^3+x^2+1 (MSB term implicit).
- `SEED`, 8'h00: MISR value loaded on start.
- `GOLDEN`, 8'h47: expected fault-free signature.
- `clk` input 1: single clock; all state changes on its rising edge.
- `rst_n` input 1: reset, asynchronous assert, active-low.
- `start` input 1: begin a run; sampled in IDLE or DONE only.
- `resp_valid` input 1: `resp` holds a CUT response this cycle.
- `resp` input `RESP_W`: CUT response.
- `busy` output 1: high in COMPACT and COMPARE.
- `done` output 1: high in DONE (level, not a pulse).
- `pass` output 1: result; meaningful only while `done`=1.
- `signature` output `SIG_W`: current MISR contents.
- `count` output `$clog2(NUM_PATTERNS+1)`: responses accepted so far this run.

## Operation
- FSM states: IDLE, COMPACT, COMPARE, DONE.
- IDLE --start--> COMPACT: `signature`←`SEED`, `count`←0, `pass`←0.
- COMPACT: on each `resp_valid`, `signature`←`{signature[SIG_W-2:0],1'b0}` ^ (`signature[SIG_W-1]` ? `POLY` : 0) ^ zero-extended `resp`; `count`←`count`+1. Without `resp_valid`, signature and count hold; gaps of any length are allowed.
- COMPACT --valid beat with `count`==`NUM_PATTERNS`-1--> COMPARE.
- COMPARE (one cycle): `pass`←(`signature`==`GOLDEN`); go to DONE.
- DONE: holds `signature`, `count`, and `pass`. `start` re-enters COMPACT with the same loading as from IDLE.
- `start` during COMPACT/COMPARE is ignored; a run cannot be restarted mid-flight.
- `resp_valid` outside COMPACT is ignored; signature and count are unchanged.
- Arithmetic: all XOR, no carries; `count` never exceeds `NUM_PATTERNS`.

## Timing
- Reset values: state IDLE, `signature`=`SEED`, `count`=0, `busy`=0, `done`=0, `pass`=0.
- Reset asserted mid-run aborts immediately to the reset values, with no partial result retained.
- `start` high at edge t makes `busy`=1 visible after t; the first response is accepted at edge t+1 at the earliest.
- The final valid beat at edge k updates `signature` and enters COMPARE. At edge k+1, `done`=1, `busy`=0, and `pass` is valid.
- Minimum run: `NUM_PATTERNS`+2 cycles from `start` to `done`.
- Outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Package `bist_pkg` holds:
  - the state enum (IDLE/COMPACT/COMPARE/DONE);
  - default `SIG_W`, `POLY`, `SEED`, `GOLDEN`;
  - `RESP_W`, which is shared with the pattern generator and CUT wrapper.
- Sub-module `misr` (`clk`, `rst_n`, `load`, `seed`, `en`, `din`, `sig`) holds the shift/XOR register. `bist_ora` contains the FSM and counter.

## Test plan
- Fault-free run: after `start`, feed the full-adder responses 00,01,01,10,01,10,10,11 back-to-back. The signature steps through 00,01,03,04,09,10,22,47. Result: `done`=1 one cycle after the last beat, `pass`=1, `signature`=8'h47, `count`=8.
- Stuck-at fault: same stream with the last response 10 instead of 11. Result: `signature`=8'h46, `pass`=0.
- Gapped valid: same fault-free stream with `resp_valid` low for 3 cycles between beats 4 and 5. Result: identical to the fault-free run (8'h47, `pass`=1), with `done` 3 cycles later.
- Ignored inputs:
  - `resp_valid`=1, `resp`=11 while in IDLE leaves `signature`=00 and `count`=0.
  - `start` pulsed at beat 3 leaves `count` and `signature` unaffected.
- Feedback path: with `SEED`=8'h80, a single run of eight 00 responses must match a hand-computed reference (first step: 80→1D). Result: `pass` = (value == `GOLDEN`).
- Reset mid-run: deassert `rst_n` after beat 5. All outputs return to reset values asynchronously; a following `start` plus the full stream gives `pass`=1.
